telemetry_framer: RTL and testbench

Parametrised telemetry framer for the cell-phone and data-logging links. It snapshots NUM_CH sensor channels (heart rate, pitch, roll, speed, ADC words) on a programmable period. It serialises each snapshot into a framed, sequence-numbered, checksummed byte stream with a valid/ready handshake. It sits between the sensor/ADC blocks and a UART transmitter, and replaces ad-hoc per-field byte muxing in the wireless path with a generic N-channel engine.

---
 rtl/telemetry_framer.sv | 153 +++++++++++++++
 tb/tb_telemetry_framer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_framer.sv
// Periodic N-channel telemetry framer: snapshots ch_data on each period tick and
// streams SYNC, {seq,NUM_CH}, hi/lo bytes per channel, checksum over valid/ready.

module telemetry_framer_lane #(
  parameter int CH_WIDTH = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [CH_WIDTH-1:0] din,
  output logic [15:0]         word
);
  logic [CH_WIDTH-1:0] snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    snap <= '0;
    else if (load) snap <= din;
  end

  always_comb begin
    word = '0;
    word[CH_WIDTH-1:0] = snap;
  end
endmodule

module telemetry_framer #(
  parameter int          NUM_CH    = 4,
  parameter int          CH_WIDTH  = 12,
  parameter int          PERIOD    = 500000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [NUM_CH*CH_WIDTH-1:0]   ch_data,
  input  logic                         tx_ready,
  output logic                         tx_valid,
  output logic [7:0]                   tx_byte,
  output logic                         busy,
  output logic [3:0]                   seq,
  output logic [7:0]                   overrun_cnt
);
  localparam int         TW      = $clog2(PERIOD);
  localparam logic [3:0] NUM_CH4 = 4'(NUM_CH);
  localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, SYNC, HDR, DATA_HI, DATA_LO, CSUM} state_t;

  state_t                   state;
  logic [TW-1:0]            timer;
  logic                     tick;
  logic                     load;
  logic                     xfer;
  logic [3:0]               ch_idx;
  logic [7:0]               sum;
  logic [7:0]               hdr;
  logic [NUM_CH-1:0][15:0]  snap;
  logic [7:0]               cur_lo;
  logic [7:0]               nxt_hi;

  assign tick = enable && (timer == TW'(PERIOD - 1));
  assign load = tick && (state == IDLE);
  assign xfer = tx_valid && tx_ready;
  assign hdr  = {seq, NUM_CH4};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                timer <= '0;
    else if (!enable || tick)  timer <= '0;
    else                       timer <= timer + TW'(1);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    telemetry_framer_lane #(.CH_WIDTH(CH_WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .din   (ch_data[i*CH_WIDTH +: CH_WIDTH]),
      .word  (snap[i])
    );
  end

  // Low byte of the channel being sent and high byte of the one after it.
  always_comb begin
    cur_lo = '0;
    nxt_hi = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == 4'(i))         cur_lo = snap[i][7:0];
      if (ch_idx + 4'd1 == 4'(i))  nxt_hi = snap[i][15:8];
    end
  end

  // tx_byte is loaded one step ahead: each transfer presents the next frame byte,
  // and sum tracks every byte presented after SYNC so the checksum is its negation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_valid    <= 1'b0;
      tx_byte     <= '0;
      busy        <= 1'b0;
      seq         <= '0;
      overrun_cnt <= '0;
      ch_idx      <= '0;
      sum         <= '0;
    end else begin
      if (tick && state != IDLE && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;
      case (state)
        IDLE: if (tick) begin
          state    <= SYNC;
          tx_valid <= 1'b1;
          tx_byte  <= SYNC_BYTE;
          busy     <= 1'b1;
          sum      <= '0;
          ch_idx   <= '0;
        end
        SYNC: if (xfer) begin
          state   <= HDR;
          tx_byte <= hdr;
          sum     <= sum + hdr;
        end
        HDR: if (xfer) begin
          state   <= DATA_HI;
          tx_byte <= snap[0][15:8];
          sum     <= sum + snap[0][15:8];
        end
        DATA_HI: if (xfer) begin
          state   <= DATA_LO;
          tx_byte <= cur_lo;
          sum     <= sum + cur_lo;
        end
        DATA_LO: if (xfer) begin
          if (ch_idx == LAST_CH) begin
            state   <= CSUM;
            tx_byte <= 8'd0 - sum;
          end else begin
            state   <= DATA_HI;
            ch_idx  <= ch_idx + 4'd1;
            tx_byte <= nxt_hi;
            sum     <= sum + nxt_hi;
          end
        end
        CSUM: if (xfer) begin
          state    <= IDLE;
          tx_valid <= 1'b0;
          tx_byte  <= '0;
          busy     <= 1'b0;
          seq      <= seq + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_telemetry_framer.sv
// Bench for telemetry_framer: vector table of whole frames, hand-written corner
// sequences, and a per-cycle reference model fed by randomized backpressure/data.

module tb_telemetry_framer;
  localparam int         NUM_CH   = 2;
  localparam int         CH_WIDTH = 12;
  localparam int         PERIOD   = 50;
  localparam int         FLEN     = 3 + 2*NUM_CH;
  localparam logic [7:0] SYNC     = 8'hA5;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       enable;
  logic [NUM_CH*CH_WIDTH-1:0] ch_data;
  logic                       tx_ready;
  logic                       tx_valid;
  logic [7:0]                 tx_byte;
  logic                       busy;
  logic [3:0]                 seq;
  logic [7:0]                 overrun_cnt;

  telemetry_framer #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .PERIOD(PERIOD), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ch_data(ch_data), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .busy(busy), .seq(seq), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] expq[$];
  logic [7:0] rxq[$];
  int         m_cnt, m_rem, m_ovr;
  logic [3:0] m_seq;
  logic       stall_prev;
  logic [7:0] stall_byte;
  logic       busy_m;

  task automatic push_frame(input logic [3:0] s, input logic [NUM_CH*CH_WIDTH-1:0] cd);
    int sum, v;
    logic [7:0] h;
    h = {s, 4'(NUM_CH)};
    expq.push_back(SYNC);
    expq.push_back(h);
    sum = int'(h);
    for (int i = 0; i < NUM_CH; i++) begin
      v = int'(cd[i*CH_WIDTH +: CH_WIDTH]);
      expq.push_back(8'(v / 256));
      expq.push_back(8'(v % 256));
      sum += v / 256 + v % 256;
    end
    expq.push_back(8'((256 - sum % 256) % 256));
  endtask

  // Outputs settle after each rising edge; inputs are stable from #1 after it,
  // so the falling edge sees exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_out", 32'({tx_valid, busy, seq, overrun_cnt, tx_byte}), 32'd0);
      m_cnt = 0; m_rem = 0; m_ovr = 0; m_seq = '0;
      expq.delete();
      stall_prev = 1'b0;
    end else begin
      chk("status", 32'({tx_valid, busy, seq, overrun_cnt}),
          32'({m_rem != 0, m_rem != 0, m_seq, 8'(m_ovr)}));
      if (stall_prev) chk("stall_hold", 32'({tx_valid, tx_byte}), 32'({1'b1, stall_byte}));
      stall_prev = tx_valid && !tx_ready;
      stall_byte = tx_byte;
      busy_m = (m_rem != 0);
      if (tx_valid && tx_ready) begin
        rxq.push_back(tx_byte);
        if (expq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_byte: got %02h, expected no transfer (t=%0t)", tx_byte, $time);
        end else begin
          chk("frame_byte", 32'(tx_byte), 32'(expq.pop_front()));
        end
        if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) m_seq++;
        end
      end
      if (enable) begin
        if (m_cnt == PERIOD - 1) begin
          m_cnt = 0;
          if (busy_m) begin
            if (m_ovr < 255) m_ovr++;
          end else begin
            push_frame(m_seq, ch_data);
            m_rem = FLEN;
          end
        end else m_cnt++;
      end else m_cnt = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct packed {
    logic [11:0]       ch0;
    logic [11:0]       ch1;
    logic [11:0]       ch0_late;
    logic [0:6][7:0]   exp;
  } vec_t;
  vec_t tbl [4];

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    cyc(3);
    rxq.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!tx_valid && n < 400) begin cyc(1); n++; end
    if (!tx_valid) begin
      n_chk++; n_fail++;
      $display("FAIL wait_valid: tx_valid still 0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic wait_rx(input int cnt, input int bound);
    int n;
    n = 0;
    while (rxq.size() < cnt && n < bound) begin cyc(1); n++; end
    if (rxq.size() < cnt) begin
      n_chk++; n_fail++;
      $display("FAIL wait_rx: got %0d bytes, expected %0d", rxq.size(), cnt);
    end
  endtask

  task automatic cmp_frame(input string nm, input logic [0:6][7:0] exp);
    for (int j = 0; j < FLEN; j++)
      chk(nm, (j < rxq.size()) ? 32'(rxq[j]) : 32'hDEAD, 32'(exp[j]));
  endtask

  initial begin
    int n;
    tbl[0] = '{12'h123, 12'hABC, 12'hFFF, {8'hA5, 8'h02, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'h14}};
    tbl[1] = '{12'hFFF, 12'hABC, 12'h000, {8'hA5, 8'h12, 8'h0F, 8'hFF, 8'h0A, 8'hBC, 8'h1A}};
    tbl[2] = '{12'h000, 12'h000, 12'h555, {8'hA5, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'hDE}};
    tbl[3] = '{12'hFFF, 12'h001, 12'h7AB, {8'hA5, 8'h32, 8'h0F, 8'hFF, 8'h00, 8'h01, 8'hBF}};

    rst_n    = 1'b0;
    enable   = 1'b1;
    tx_ready = 1'b1;
    ch_data  = {tbl[0].ch1, tbl[0].ch0};
    cyc(2);

    // Frame table, with ch0 rewritten just after each snapshot.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      ch_data = {tbl[k].ch1, tbl[k].ch0};
      wait_valid(n);
      if (k == 0) chk("first_latency", n, PERIOD);
      ch_data = {tbl[k].ch1, tbl[k].ch0_late};
      wait_rx(FLEN, 200);
      cmp_frame("tbl_frame", tbl[k].exp);
      chk("seq_after", 32'(seq), k + 1);
      rxq.delete();
    end

    // Randomized backpressure and data.
    for (int i = 0; i < 600; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) ch_data = (NUM_CH*CH_WIDTH)'($urandom);
      cyc(1);
    end
    tx_ready = 1'b1;
    cyc(60);

    // enable dropped mid-frame: frame finishes, nothing follows.
    n = 0;
    while (tx_valid && n < 50) begin cyc(1); n++; end
    rxq.delete();
    wait_valid(n);
    enable = 1'b0;
    cyc(100);
    chk("en_drop_bytes", rxq.size(), FLEN);
    chk("en_drop_idle", 32'(tx_valid), 32'd0);
    enable = 1'b1;

    // Overrun while stalled.
    ch_data  = {tbl[0].ch1, tbl[0].ch0};
    tx_ready = 1'b0;
    do_reset();
    wait_valid(n);
    cyc(120);
    chk("overrun_cnt", 32'(overrun_cnt), 32'd2);
    tx_ready = 1'b1;
    wait_rx(FLEN, 100);
    cmp_frame("overrun_frame", tbl[0].exp);
    cyc(2);
    chk("no_queued", 32'(tx_valid), 32'd0);

    // Reset after the third byte.
    do_reset();
    wait_rx(3, 200);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    cyc(2);
    rxq.delete();
    rst_n = 1'b1;
    wait_valid(n);
    chk("rst_latency", n, PERIOD);
    wait_rx(FLEN, 100);
    cmp_frame("rst_frame", tbl[0].exp);

    // Sequence wrap over 17 frames, then overrun saturation.
    do_reset();
    wait_rx(17 * FLEN, 1200);
    for (int k = 0; k < 17; k++)
      chk("hdr_seq", (k*FLEN + 1 < rxq.size()) ? 32'(rxq[k*FLEN + 1]) : 32'hDEAD,
          32'({4'(k % 16), 4'(NUM_CH)}));
    tx_ready = 1'b0;
    cyc(300 * PERIOD);
    chk("ovr_sat", 32'(overrun_cnt), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
